fetch_decode_queue: RTL and testbench
=====================================

# fetch_decode_queue

Parametrised fetch-to-decode buffer replacing the single-entry fetch pipeline register. It is a DEPTH-entry circular FIFO carrying PC, instruction word and exception code, with valid/ready handshakes on both sides, synchronous flush, and registered copies of reset and flush for downstream stages. It sits between instruction fetch (after the I-cache response) and the decode stage. It decouples fetch from decode stalls without dropping or duplicating instructions.

## Interface
Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction word width
- EXC_W, 6, fetch exception code width (0 = no exception)
- DEPTH, 4, entry count; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on posedge
- resetn  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush (branch mispredict / exception); synchronous
- fe_valid  in  1  fetch presents an entry
- fe_ready  out  1  queue can accept an entry
- fe_pc  in  ADDR_W  PC of fetched instruction
- fe_inst  in  INST_W  instruction word
- fe_exc  in  EXC_W  fetch exception code
- de_valid  out  1  head entry valid
- de_ready  in  1  decode consumes head this cycle
- de_pc  out  ADDR_W  head PC; zero when empty
- de_inst  out  INST_W  head instruction; zero when empty
- de_exc  out  EXC_W  head exception code; zero when empty
- count  out  $clog2(DEPTH)+1  current occupancy
- resetn_q  out  1  resetn delayed one cycle
- flush_q  out  1  flush delayed one cycle

## Operation
- Storage: DEPTH×(ADDR_W+INST_W+EXC_W) array; wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH; count is tracked explicitly.
- push = fe_valid & fe_ready; pop = de_valid & de_ready.
- fe_ready = (count < DEPTH). It is a function of registered state only, with no combinational path from de_ready.
- de_valid = (count != 0). de_pc/de_inst/de_exc read storage[rd_ptr] when valid and are forced to zero when empty. A zero PC is the bubble convention for decode.
- Per cycle, in priority order:
  1. !resetn: wr_ptr, rd_ptr and count go to 0. Storage contents are don't-care.
  2. flush: wr_ptr, rd_ptr and count go to 0. Any push or pop in this cycle is discarded.
  3. Otherwise:
     - push writes storage[wr_ptr] and increments wr_ptr.
     - pop increments rd_ptr.
     - count += push − pop. When push and pop occur together, count is unchanged.
- Push and pop in the same cycle are legal at any occupancy from 1 to DEPTH−1.
- When empty, pop cannot occur; a push that cycle lands and becomes visible the next cycle.
- When full, fe_ready is 0. A concurrent pop frees a slot, and fe_ready rises the next cycle.
- resetn_q and flush_q register resetn and flush every cycle unconditionally. They are not gated by reset.
- Entries carrying fe_exc != 0 are queued like any other entry; the queue does not interpret exception codes.

## Timing
- Reset values: fe_ready=1, de_valid=0, de_pc/de_inst/de_exc=0, count=0. resetn_q=0 and flush_q=0 after the first reset edge.
- Latency: an entry pushed at edge N is visible on de_* in the cycle after N, so the minimum push-to-pop latency is 1 cycle. There is no combinational fe→de bypass.
- Throughput: 1 entry per cycle sustained when decode never stalls.
- Flush asserted in cycle N: de_valid=0 and count=0 from cycle N+1. Fetch may push again in cycle N+1.
- Reset asserted mid-stream behaves identically to flush. It additionally drives resetn_q low one cycle later.

## Structure
- A shared package holds:
  - the bubble value (zero PC/instruction)
  - the EXC_W default
  - the no-exception code constant
- The sub-module `fdq_ram`, a simple DEPTH×W register-file with one synchronous write port and one asynchronous read port, is natural.
- Pointer, count and handshake logic live in the top module.

## Test plan
- Reset, then idle: count=0, de_valid=0, de_pc=0, fe_ready=1 for 10 cycles.
- Streaming: push PCs 0x1c000000, 0x1c000004, … at 1/cycle with de_ready=1. Decode sees the same sequence, each one cycle later, and count stays at 1.
- Fill/wrap: hold de_ready=0 and push 4 entries (DEPTH=4). fe_ready=0 and count=4. Then pop/push concurrently for 8 cycles. Order is preserved across pointer wrap, and no entry is lost or duplicated.
- Flush with 3 entries queued and a concurrent push: next cycle count=0, de_valid=0 and flush_q=1. The discarded push never appears at decode.
- Exception passthrough: push fe_exc=0x08 with PC 0x1c000010. Decode receives the exception code and PC unchanged.
- Reset mid-stream with 2 entries: behaves as a flush, and resetn_q goes low one cycle after resetn.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// rtl/fetch_decode_queue_pkg.sv - shared constants for the fetch-to-decode queue
package fetch_decode_queue_pkg;
  localparam int EXC_W_DEFAULT = 6;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_NONE = '0;
  // Zero PC/instruction is how decode recognises a bubble.
  localparam logic [63:0] BUBBLE = 64'd0;
endpackage

// File: rtl/fdq_ram.sv
// rtl/fdq_ram.sv - DEPTH x W register file, one synchronous write, one asynchronous read
module fdq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - circular FIFO between instruction fetch and decode
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = EXC_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     fe_valid,
  output logic                     fe_ready,
  input  logic [ADDR_W-1:0]        fe_pc,
  input  logic [INST_W-1:0]        fe_inst,
  input  logic [EXC_W-1:0]         fe_exc,
  output logic                     de_valid,
  input  logic                     de_ready,
  output logic [ADDR_W-1:0]        de_pc,
  output logic [INST_W-1:0]        de_inst,
  output logic [EXC_W-1:0]         de_exc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resetn_q,
  output logic                     flush_q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int W  = ADDR_W + INST_W + EXC_W;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  rd_data;
  logic          push, pop;

  // Handshakes depend only on registered count, so no de_ready -> fe_ready path.
  assign fe_ready = (count < CW'(DEPTH));
  assign de_valid = (count != '0);
  assign push     = fe_valid & fe_ready;
  assign pop      = de_valid & de_ready;

  fdq_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clk   (clk),
    .we    (push & resetn & ~flush),
    .waddr (wr_ptr),
    .wdata ({fe_pc, fe_inst, fe_exc}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    resetn_q <= resetn;
    flush_q  <= flush;
  end

  always_comb begin
    de_pc   = ADDR_W'(BUBBLE);
    de_inst = INST_W'(BUBBLE);
    de_exc  = EXC_W'(EXC_NONE);
    if (de_valid) begin
      {de_pc, de_inst, de_exc} = rd_data;
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn, flush, fe_valid, fe_ready, de_valid, de_ready;
  logic [31:0] fe_pc, fe_inst, de_pc, de_inst;
  logic [5:0]  fe_exc, de_exc;
  logic [2:0]  count;
  logic        resetn_q, flush_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  exc;
  } ent_t;

  ent_t q[$];
  logic prev_r, prev_f;
  bit   model_init = 0;

  typedef struct {
    logic        r, f, fv;
    logic [31:0] pc;
    logic [5:0]  exc;
    logic        dr;
    int          e_count;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [5:0]  e_exc;
    logic        e_ready;
    logic        e_fq;
  } vec_t;

  vec_t vecs[13];

  fetch_decode_queue #(.ADDR_W(32), .INST_W(32), .EXC_W(6), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .fe_valid(fe_valid), .fe_ready(fe_ready),
    .fe_pc(fe_pc), .fe_inst(fe_inst), .fe_exc(fe_exc),
    .de_valid(de_valid), .de_ready(de_ready),
    .de_pc(de_pc), .de_inst(de_inst), .de_exc(de_exc),
    .count(count), .resetn_q(resetn_q), .flush_q(flush_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  task automatic model_check();
    if (!model_init) return;
    chk("m_count", 64'(count), 64'(q.size()));
    chk("m_fe_ready", 64'(fe_ready), 64'(q.size() < DEPTH));
    chk("m_de_valid", 64'(de_valid), 64'(q.size() != 0));
    chk("m_de_pc", 64'(de_pc), q.size() ? 64'(q[0].pc) : 64'd0);
    chk("m_de_inst", 64'(de_inst), q.size() ? 64'(q[0].inst) : 64'd0);
    chk("m_de_exc", 64'(de_exc), q.size() ? 64'(q[0].exc) : 64'd0);
    chk("m_resetn_q", 64'(resetn_q), 64'(prev_r));
    chk("m_flush_q", 64'(flush_q), 64'(prev_f));
  endtask

  task automatic model_update();
    bit do_push, do_pop;
    ent_t e;
    do_push = fe_valid && (q.size() < DEPTH);
    do_pop  = de_ready && (q.size() > 0);
    if (!resetn || flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = fe_pc; e.inst = fe_inst; e.exc = fe_exc;
        q.push_back(e);
      end
    end
    prev_r = resetn;
    prev_f = flush;
    if (!resetn) model_init = 1;
  endtask

  // Drive one cycle: inputs held from just after one edge to just after the next.
  task automatic cycle(input logic r, input logic f, input logic fv,
                       input logic [31:0] pc, input logic [5:0] exc, input logic dr);
    resetn = r; flush = f; fe_valid = fv; fe_pc = pc; fe_inst = inst_of(pc);
    fe_exc = exc; de_ready = dr;
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    localparam logic [31:0] B = 32'h1c00_0000;
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,    6'h00, 1'b0, 0, 1'b0, 32'd0,    6'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'd0,    6'h00, 1'b0, 0, 1'b0, 32'd0,    6'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, B+32'h10, 6'h08, 1'b0, 1, 1'b1, B+32'h10, 6'h08, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, B+32'h14, 6'h00, 1'b1, 1, 1'b1, B+32'h14, 6'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'd0,    6'h00, 1'b1, 0, 1'b0, 32'd0,    6'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, B+32'h20, 6'h01, 1'b0, 1, 1'b1, B+32'h20, 6'h01, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, B+32'h24, 6'h00, 1'b0, 2, 1'b1, B+32'h20, 6'h01, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, B+32'h28, 6'h00, 1'b0, 3, 1'b1, B+32'h20, 6'h01, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, B+32'h2c, 6'h00, 1'b0, 4, 1'b1, B+32'h20, 6'h01, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, B+32'h30, 6'h00, 1'b0, 4, 1'b1, B+32'h20, 6'h01, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, B+32'h30, 6'h00, 1'b1, 3, 1'b1, B+32'h24, 6'h00, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, B+32'h34, 6'h00, 1'b1, 0, 1'b0, 32'd0,    6'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'd0,    6'h00, 1'b1, 0, 1'b0, 32'd0,    6'h00, 1'b1, 1'b0};

    resetn = 1'b0; flush = 1'b0; fe_valid = 1'b0; de_ready = 1'b0;
    fe_pc = '0; fe_inst = '0; fe_exc = '0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].f, vecs[i].fv, vecs[i].pc, vecs[i].exc, vecs[i].dr);
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_count));
      chk($sformatf("v%0d_valid", i), 64'(de_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_pc", i), 64'(de_pc), 64'(vecs[i].e_pc));
      chk($sformatf("v%0d_exc", i), 64'(de_exc), 64'(vecs[i].e_exc));
      chk($sformatf("v%0d_ready", i), 64'(fe_ready), 64'(vecs[i].e_ready));
      chk($sformatf("v%0d_flush_q", i), 64'(flush_q), 64'(vecs[i].e_fq));
    end

    // Reset then idle for 10 cycles.
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_resetn_q", 64'(resetn_q), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
      chk("idle_count", 64'(count), 64'd0);
      chk("idle_pc", 64'(de_pc), 64'd0);
      chk("idle_ready", 64'(fe_ready), 64'd1);
    end

    // Streaming at one entry per cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b1, B + 32'(4*i), '0, 1'b1);
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_pc", 64'(de_pc), 64'(B + 32'(4*i)));
    end
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("stream_drain", 64'(count), 64'd0);

    // Fill, then concurrent push/pop across pointer wrap, then drain.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, B + 32'h100 + 32'(4*i), '0, 1'b0);
    chk("full_ready", 64'(fe_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, B + 32'h200 + 32'(4*i), '0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("wrap_empty", 64'(count), 64'd0);

    // Flush with three queued and a concurrent push.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, B + 32'h300 + 32'(4*i), '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, B + 32'h3f0, '0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(de_valid), 64'd0);
    chk("flush_q", 64'(flush_q), 64'd1);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("flush_discard", 64'(de_valid), 64'd0);

    // Reset mid-stream with two entries.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b1, B + 32'h400 + 32'(4*i), '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, B + 32'h4f0, '0, 1'b1);
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_resetn_q", 64'(resetn_q), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("mrst_resetn_q_hi", 64'(resetn_q), 64'd1);
    chk("mrst_valid", 64'(de_valid), 64'd0);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), $urandom, 6'($urandom_range(0, 63)),
            ($urandom_range(0, 2) != 0));
    end
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
